// File: rtl/dac_arb_pkg.sv
// Shared definitions for the DAC arbiter: FSM state encoding and default sizing.
package dac_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_W_DATA    = 16;
    localparam int DEF_W_CHS     = 3;
    localparam int DEF_N_CHAN    = 8;
    localparam int DEF_T_TIMEOUT = 63;

endpackage

// File: rtl/dac_arbiter_if.sv
// Issue/completion handshake between the DAC arbiter (master) and the DAC controller (slave).
interface dac_arbiter_if
    import dac_arb_pkg::*;
#(
    parameter int W_DATA = DEF_W_DATA,
    parameter int W_CHS  = DEF_W_CHS
) ();

    logic [W_DATA-1:0] data_out;
    logic [W_CHS-1:0]  channel_out;
    logic              data_valid_out;
    logic              dac_done_in;

    modport master (
        output data_out,
        output channel_out,
        output data_valid_out,
        input  dac_done_in
    );

    modport slave (
        input  data_out,
        input  channel_out,
        input  data_valid_out,
        output dac_done_in
    );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker: first pending channel after last_issued, wrapping to 0.
module rr_select #(
    parameter int N_CHAN = 8,
    parameter int W_CHS  = 3
) (
    input  logic [N_CHAN-1:0] pending,
    input  logic [W_CHS-1:0]  last_issued,
    output logic [W_CHS-1:0]  grant,
    output logic              any_pending
);

    // Channels above last_issued get first look, then the search wraps to channel 0.
    always_comb begin
        grant       = '0;
        any_pending = 1'b0;
        for (int k = 0; k < N_CHAN; k++) begin
            if (!any_pending && (k > int'(last_issued)) && pending[k]) begin
                grant       = W_CHS'(k);
                any_pending = 1'b1;
            end
        end
        for (int k = 0; k < N_CHAN; k++) begin
            if (!any_pending && (k <= int'(last_issued)) && pending[k]) begin
                grant       = W_CHS'(k);
                any_pending = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_arbiter.sv
// Multi-channel DAC update arbiter with round-robin issue and a done watchdog.
// Optional macro DAC_ARB_DEDUP_EN drops captures equal to the channel's last-issued word.
module dac_arbiter
    import dac_arb_pkg::*;
#(
    parameter int W_DATA    = DEF_W_DATA,
    parameter int W_CHS     = DEF_W_CHS,
    parameter int N_CHAN    = DEF_N_CHAN,
    parameter int T_TIMEOUT = DEF_T_TIMEOUT
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic [N_CHAN*W_DATA-1:0] data_in,
    input  logic [N_CHAN-1:0]        data_valid_in,
    dac_arbiter_if.master            dac,
    output logic                     busy_out,
    output logic [N_CHAN-1:0]        pending_out,
    output logic                     timeout_out
);

    localparam int W_WD = $clog2(T_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [N_CHAN-1:0] pending_q;
    logic [N_CHAN-1:0] cap;
    logic [W_DATA-1:0] slot_q [N_CHAN];
    logic [W_CHS-1:0]  last_issued_q;
    logic [W_CHS-1:0]  grant;
    logic [W_CHS-1:0]  channel_q;
    logic [W_DATA-1:0] data_q;
    logic [W_WD-1:0]   wd_cnt_q;
    logic              timeout_q;
    logic              any_pending;
    logic              issue_now;
    logic              wd_expire;

    rr_select #(
        .N_CHAN (N_CHAN),
        .W_CHS  (W_CHS)
    ) u_rr_select (
        .pending     (pending_q),
        .last_issued (last_issued_q),
        .grant       (grant),
        .any_pending (any_pending)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A done pulse that coincides with the last watchdog cycle counts as a normal completion.
    always_comb begin
        state_d   = state_q;
        issue_now = 1'b0;
        wd_expire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    state_d   = ST_ISSUE;
                    issue_now = 1'b1;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (dac.dac_done_in) begin
                    state_d = ST_GAP;
                end else if (wd_cnt_q == W_WD'(T_TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef DAC_ARB_DEDUP_EN
    logic [W_DATA-1:0] last_word_q [N_CHAN];

    always_comb begin
        cap = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            cap[k] = data_valid_in[k] && (data_in[k*W_DATA +: W_DATA] != last_word_q[k]);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int k = 0; k < N_CHAN; k++) begin
                last_word_q[k] <= '0;
            end
        end else if (issue_now) begin
            last_word_q[grant] <= slot_q[grant];
        end
    end
`else
    assign cap = data_valid_in;
`endif

    // A capture on the channel being issued wins over the clear, so the new word stays queued.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pending_q     <= '0;
            data_q        <= '0;
            channel_q     <= '0;
            last_issued_q <= W_CHS'(N_CHAN - 1);
            for (int k = 0; k < N_CHAN; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CHAN; k++) begin
                if (cap[k]) begin
                    slot_q[k]    <= data_in[k*W_DATA +: W_DATA];
                    pending_q[k] <= 1'b1;
                end else if (issue_now && (grant == W_CHS'(k))) begin
                    pending_q[k] <= 1'b0;
                end
            end
            if (issue_now) begin
                data_q        <= slot_q[grant];
                channel_q     <= grant;
                last_issued_q <= grant;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE) begin
                wd_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                wd_cnt_q <= wd_cnt_q + W_WD'(1);
            end
            if (wd_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign dac.data_out       = data_q;
    assign dac.channel_out    = channel_q;
    assign dac.data_valid_out = (state_q == ST_ISSUE);
    assign busy_out           = (state_q != ST_IDLE);
    assign pending_out        = pending_q;
    assign timeout_out        = timeout_q;

endmodule

// File: doc/dac_arbiter.md
DAC_ARBITER -- requirements
Module: dac_arbiter

Interface
REQ-001 Parameter W_DATA, default 16: width of each channel's data word.
REQ-002 Parameter W_CHS, default 3: width of the channel select.
REQ-003 Parameter N_CHAN, default 8: number of channels, at most 2^W_CHS.
REQ-004 Parameter T_TIMEOUT, default 63: watchdog limit in cycles for dac_done_in.
REQ-005 clk_in  in  1  single system clock; all state changes on the rising edge.
REQ-006 reset_n_in  in  1  reset, asynchronous and active-low.
REQ-007 data_in  in  N_CHAN*W_DATA  per-channel data words, flattened; channel k occupies bits [k*W_DATA +: W_DATA].
REQ-008 data_valid_in  in  N_CHAN  per-channel one-cycle update strobes from the PID stages.
REQ-009 dac_done_in  in  1  one-cycle completion pulse from the DAC controller.
REQ-010 data_out  out  W_DATA  word issued to the DAC controller.
REQ-011 channel_out  out  W_CHS  channel issued to the DAC controller.
REQ-012 data_valid_out  out  1  one-cycle issue strobe to the DAC controller.
REQ-013 busy_out  out  1  high whenever the state is not ST_IDLE.
REQ-014 pending_out  out  N_CHAN  per-channel pending flags.
REQ-015 timeout_out  out  1  sticky watchdog error flag.

Function
REQ-016 Capture: when data_valid_in[k]=1, the block SHALL copy the channel k word into slot k and set pending[k] on the next edge; a newer word overwrites an unissued older one.
REQ-017 States SHALL be ST_IDLE, ST_ISSUE, ST_WAIT and ST_GAP.
REQ-018 ST_IDLE -> ST_ISSUE occurs when any pending bit is set; otherwise the FSM stays in ST_IDLE.
REQ-019 ST_ISSUE -> ST_WAIT occurs unconditionally after one cycle.
REQ-020 ST_WAIT -> ST_GAP occurs on dac_done_in=1 or on watchdog expiry.
REQ-021 ST_GAP -> ST_IDLE occurs unconditionally after one cycle.
REQ-022 Selection: on the ST_IDLE->ST_ISSUE edge, the block SHALL pick the first pending channel in round-robin order, starting at last_issued+1 modulo N_CHAN.
REQ-023 On that same edge, the block SHALL register data_out and channel_out and clear the pending bit of the selected channel.
REQ-024 data_valid_out SHALL be high exactly during ST_ISSUE, for one cycle per issue.
REQ-025 data_out and channel_out SHALL stay stable from ST_ISSUE until the next issue.
REQ-026 Latency: a strobe at edge N with the FSM idle and no other channel pending SHALL produce data_valid_out high in cycle N+2.
REQ-027 Simultaneous capture and clear on the same channel: the capture wins, so pending stays set and the new word is issued later.
REQ-028 Watchdog: a counter SHALL clear on entry to ST_WAIT and increment each ST_WAIT cycle.
REQ-029 When the watchdog count reaches T_TIMEOUT, the block SHALL set timeout_out and leave ST_WAIT.
REQ-030 The issued channel SHALL NOT be re-marked pending on timeout.
REQ-031 dac_done_in outside ST_WAIT SHALL be ignored.
REQ-032 Wrap-around: round-robin order SHALL wrap from channel N_CHAN-1 to channel 0.

Reset
REQ-033 While reset_n_in=0, the state SHALL be ST_IDLE and pending, all slots, data_out, channel_out, data_valid_out, busy_out, timeout_out and the watchdog counter SHALL be 0.
REQ-034 While reset_n_in=0, last_issued SHALL be N_CHAN-1, so channel 0 has first priority.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction immediately; no data_valid_out pulse follows deassertion until new strobes arrive.

Configuration
REQ-036 With macro DAC_ARB_DEDUP_EN defined, the block SHALL keep a per-channel last-issued word.
REQ-037 With DAC_ARB_DEDUP_EN defined, a capture equal to that channel's last-issued word SHALL NOT set pending; the last-issued words reset to 0.
REQ-038 Without DAC_ARB_DEDUP_EN, every strobe SHALL set pending and no last-issued storage is built.

Structure
REQ-039 Package dac_arb_pkg SHALL hold the state encoding (2 bits) and the default W_DATA, W_CHS, N_CHAN and T_TIMEOUT constants.
REQ-040 Sub-module rr_select SHALL be purely combinational: inputs are the N_CHAN pending vector and last_issued; outputs are the grant index and an any-pending flag.

Verification
REQ-041 Single issue: strobe channel 2 with 0x1234 -> data_valid_out high 2 cycles later, channel_out=2, data_out=0x1234; dac_done_in after 36 cycles -> busy_out low 2 cycles after done.
REQ-042 Round robin: strobe all 8 channels in one cycle, ack each -> issue order 0,1,...,7; then strobe channels 0 and 5 with last_issued=7 -> order 0,5.
REQ-043 Overwrite: strobe channel 3 with 0x0001, then 0x0002 while channel 3 is pending -> a single issue with data_out=0x0002.
REQ-044 Capture-at-issue collision: strobe channel 4 in the cycle it is selected -> two issues of channel 4, with the second carrying the new word.
REQ-045 Timeout: never assert dac_done_in -> timeout_out=1 after 63 ST_WAIT cycles and the FSM proceeds to the next pending channel; reset mid-ST_WAIT -> all outputs 0.
REQ-046 Dedup (DAC_ARB_DEDUP_EN defined): issue 0x00AA on channel 1, then strobe 0x00AA again -> no issue; strobe 0x00AB -> one issue.
